// File: rtl/seg7_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_driver
//  Purpose  : Two-digit multiplexed 7-segment driver with tear-free snapshots
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
   parameter int REFRESH_DIV   = 50000,
   parameter int ACTIVE_LOW    = 1,
   parameter int BLANK_LEADING = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   input  logic       enable,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame_tick
);

   localparam int         CNT_W   = $clog2(REFRESH_DIV);
   localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [1:0] AN_OFF  = (ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

   typedef enum logic [0:0] {
      SCAN_ONES = 1'b0,
      SCAN_TENS = 1'b1
   } scan_state_t;

   scan_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       snap1;
   logic [3:0]       snap2;
   logic             tick;
   logic [6:0]       seg_raw;
   logic [1:0]       an_raw;

   // Segment pattern, active-true, bit 0 = a ... bit 6 = g
   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'b0111111;
         4'd1:    decode = 7'b0000110;
         4'd2:    decode = 7'b1011011;
         4'd3:    decode = 7'b1001111;
         4'd4:    decode = 7'b1100110;
         4'd5:    decode = 7'b1101101;
         4'd6:    decode = 7'b1111101;
         4'd7:    decode = 7'b0000111;
         4'd8:    decode = 7'b1111111;
         4'd9:    decode = 7'b1101111;
         default: decode = 7'b1000000;
      endcase
   endfunction

   assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

   always_comb begin
      seg_raw = 7'b0000000;
      an_raw  = 2'b00;
      if (state == SCAN_TENS) begin
         // A zero tens digit goes fully dark; non-BCD codes still show a dash
         if (!((BLANK_LEADING != 0) && (snap2 == 4'd0))) begin
            seg_raw = decode(snap2);
            an_raw  = 2'b10;
         end
      end else begin
         seg_raw = decode(snap1);
         an_raw  = 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         state      <= SCAN_ONES;
         snap1      <= 4'd0;
         snap2      <= 4'd0;
         frame_tick <= 1'b0;
         seg        <= SEG_OFF;
         an         <= AN_OFF;
      end else begin
         cnt        <= tick ? '0 : cnt + 1'b1;
         frame_tick <= tick && (state == SCAN_TENS);
         if (tick) begin
            state <= (state == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
            if (state == SCAN_TENS) begin
               snap1 <= digit1;
               snap2 <= digit2;
            end
         end
         if (enable) begin
            seg <= seg_raw ^ SEG_OFF;
            an  <= an_raw ^ AN_OFF;
         end else begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clocks per digit dwell; legal range 2..2^20.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1: 1 means seg and an are driven low-true, 0 means high-true.
REQ-003 SHALL have parameter BLANK_LEADING, default 1: 1 means the tens digit is blanked when it equals 0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port digit1, input, 4 bits: BCD ones digit from the counter stage.
REQ-007 SHALL have port digit2, input, 4 bits: BCD tens digit from the counter stage.
REQ-008 SHALL have port enable, input, 1 bit: 1 means display on, 0 means all segments and anodes inactive.
REQ-009 SHALL have port seg, output, 7 bits: segment drive, with seg[0] to seg[6] being a to g; registered.
REQ-010 SHALL have port an, output, 2 bits: digit select, with an[0] for ones and an[1] for tens; registered.
REQ-011 SHALL have port frame_tick, output, 1 bit: one-clock pulse on each snapshot load; registered.

Function
REQ-012 SHALL contain prescaler cnt counting 0..REFRESH_DIV-1 and wrapping to 0; tick = (cnt == REFRESH_DIV-1).
REQ-013 SHALL implement a 2-state scan FSM, SCAN_ONES and SCAN_TENS, which toggles on each tick and otherwise holds.
REQ-014 SHALL hold snapshot registers snap1 and snap2, loaded from digit1 and digit2 only on the tick edge where the state is SCAN_TENS (frame boundary).
REQ-015 SHALL keep snap1 and snap2 unchanged between frame boundaries regardless of input changes, so there is no tearing.
REQ-016 SHALL drive frame_tick high for exactly the one clock in which snap1 and snap2 first hold newly loaded values, and low otherwise.
REQ-017 SHALL register seg and an each clock from the current FSM state and snapshots, giving 1-clock latency from a state change to the outputs.
REQ-018 SHALL decode in SCAN_ONES: an[0] active, an[1] inactive, and seg = decode(snap1).
REQ-019 SHALL decode in SCAN_TENS: an[1] active, an[0] inactive, and seg = decode(snap2).
REQ-020 SHALL in SCAN_TENS, with BLANK_LEADING=1 and snap2==0, drive an[1] and all seg bits inactive.
REQ-021 SHALL use the decode table, active-true with bits listed: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
REQ-022 SHALL decode non-BCD codes 10..15 as a dash (g only) and never blank them.
REQ-023 SHALL invert all seg and an bits when ACTIVE_LOW=1.
REQ-024 SHALL with enable=0 force seg and an inactive on the next edge, while cnt, FSM, snapshots and frame_tick continue to run.
REQ-025 SHALL give priority rst > enable > scan decode when events coincide.

Reset
REQ-026 SHALL on any edge with rst=1 set: cnt=0, state=SCAN_ONES, snap1=0, snap2=0, frame_tick=0, and seg and an all inactive.
REQ-027 SHALL treat reset asserted mid-frame the same as at power-up, with no partial output retained.
REQ-028 SHALL on the first edge after rst falls (enable=1) output an[0] active and seg = decode(0), with tens blanked when BLANK_LEADING=1.

Verification
REQ-029 SHALL be verified with REFRESH_DIV=4, ACTIVE_LOW=1 and BLANK_LEADING=1: hold digit2=4 and digit1=7 after reset, then an alternates 2'b10 and 2'b01 every 4 clocks, seg shows 7'b1111000 (ones, "7") and 7'b0011001 (tens, "4"), and frame_tick pulses every 8 clocks.
REQ-030 SHALL be verified for tear-free update: change digit1 from 3 to 8 in mid-SCAN_ONES, then ones stays "3" until the frame_tick, and "8" appears at the next SCAN_ONES.
REQ-031 SHALL be verified for leading blank: digit2=0 and digit1=5, then during SCAN_TENS an=2'b11 and seg=7'b1111111, and during SCAN_ONES seg=7'b0010010.
REQ-032 SHALL be verified for invalid code: digit2=4'hC, then during SCAN_TENS seg=7'b0111111 (dash) and an[1]=0.
REQ-033 SHALL be verified for enable: drop enable for 10 clocks, then the next edge gives an=2'b11 and seg=7'b1111111, frame_tick still pulses, and the display resumes on the first edge after enable returns to 1.
REQ-034 SHALL be verified for reset mid-frame: assert rst for 1 clock during SCAN_TENS, then the following edge gives an=2'b11 and frame_tick=0, and after release the scan restarts in SCAN_ONES with cnt from 0.
